tone_decoder: RTL and testbench
===============================

// Module: tone_decoder
// PURPOSE
//  Receive-side counterpart of the PWM note generator. Measures the period of an
//  incoming square wave (buzzer drive tap or comparator output) in clk cycles and
//  classifies it against the 7-note table (DO..XI). A note is reported only after
//  STABLE_N consecutive matching periods. Reports silence after TIMEOUT cycles
//  with no rising edge. Feeds the melody checker and the LED note display.
// PARAMETERS
//  CNT_W     20      period counter / period output width
//  TIMEOUT   100000  clk cycles without a rising edge -> silence
//  TOL       150     +/- match window in cycles (must stay < 175: MI/FA are 350 apart)
//  STABLE_N  3       consecutive identical classifications required to commit a note
//  DO..XI    47750,42550,37900,37550,31850,28400,25400  full period of each note in cycles
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active-high
//  tone_in       in   1      asynchronous square-wave input
//  note          out  3      committed note: 0 = silence/none, 1 = DO .. 7 = XI
//  note_valid    out  1      one-cycle pulse whenever note changes value
//  period        out  CNT_W  last measured full period in cycles
//  period_valid  out  1      one-cycle pulse when period updates
//  locked        out  1      high while note != 0
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): note=0, note_valid=0, period=0, period_valid=0,
//   locked=0, cnt=0, armed=0, cand=0, stable=0, synchronizer flops=0.
//  Input: 2-FF synchronizer, then rise = s2 & ~s3. rise asserts 3 cycles after tone_in rises.
//  Counter: cnt increments every cycle and saturates at TIMEOUT.
//   On rise: cnt<=0. If armed: period<=cnt+1, period_valid pulses next cycle.
//   If not armed (first edge after reset or timeout): the period is discarded and armed<=1.
//  Classify (registered, 1 cycle after period update): match = lowest index k whose
//   |period - NOTE_k| <= TOL, else 0 (unmatched). Compare using CNT_W+1 signed arithmetic.
//  Commit logic, evaluated once per classification:
//   - match==0: cand<=0, stable<=0. note holds.
//   - match==cand: stable<=min(stable+1,STABLE_N).
//   - match!=cand: cand<=match, stable<=1.
//   - The cycle stable reaches STABLE_N with cand != note: note<=cand, and note_valid
//     pulses in that same cycle as note updates. Re-confirming the current note gives no pulse.
//  Timeout: when cnt==TIMEOUT-1 and no rise, then on the next cycle: armed<=0, cand<=0,
//   stable<=0. If note!=0: note<=0 and note_valid pulses. period holds its last value.
//  Simultaneous: rise on the cycle cnt would reach TIMEOUT -> the rise wins, cnt<=0, no
//   timeout, and the period (=TIMEOUT) classifies as unmatched.
//  Latency: tone_in rise completing the STABLE_N-th matching period -> note update = 3+1+1 cycles.
//  Reset mid-measurement clears everything. The next rise is discarded (unarmed).
//  locked = (note != 0), registered with note.
// TESTING
//  1 Assert rst for 2 cycles with tone_in toggling -> all outputs 0, no pulses.
//  2 Square wave, period 47750, 5 rises -> first rise discarded; period=47750 on rises 2-5;
//    note=1 and one note_valid pulse after rise 4; locked=1.
//  3 Switch the wave to period 31850 -> note=5 after 3 matching periods, exactly one
//    note_valid pulse; no intermediate note values.
//  4 Period 47750+151 -> unmatched; note stays 1; period=47901.
//    Period 37550+100 -> classifies as FA (4), not MI.
//  5 Alternate 42550/37900 every period -> stable never reaches 3; note and note_valid unchanged.
//  6 Hold tone_in low -> TIMEOUT cycles after the last rise, note=0 with one pulse and locked=0.
//    Assert rst mid-period -> cleared; the next rise yields no period_valid.

Source files
------------

// File: rtl/tone_decoder.sv
// Measures the period of an incoming square wave and classifies it against the
// 7-note table. A note commits after STABLE_N matching periods; no edges for TIMEOUT cycles means silence.
module tone_decoder #(
    parameter int CNT_W    = 20,
    parameter int TIMEOUT  = 100000,
    parameter int TOL      = 150,
    parameter int STABLE_N = 3,
    parameter int DO       = 47750,
    parameter int RE       = 42550,
    parameter int MI       = 37900,
    parameter int FA       = 37550,
    parameter int SO       = 31850,
    parameter int LA       = 28400,
    parameter int XI       = 25400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [2:0]       note,
    output logic             note_valid,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked
);

    localparam int SW = (STABLE_N < 2) ? 1 : $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0]        TO_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]        TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W + 1)'(TOL);
    localparam logic [SW-1:0]           STABLE_M = SW'(STABLE_N);
    localparam logic [CNT_W-1:0] NOTE_V [7] = '{CNT_W'(DO), CNT_W'(RE), CNT_W'(MI),
                                                CNT_W'(FA), CNT_W'(SO), CNT_W'(LA), CNT_W'(XI)};

    // sync_q[0] = first stage, sync_q[1] = second stage, sync_q[2] = edge-detect delay
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [2:0]       cand_q, cand_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [2:0]       note_q, note_d;
    logic             note_valid_q, note_valid_d;
    logic             locked_q, locked_d;

    logic             rise;
    logic             timeout;
    logic [2:0]       match;
    logic signed [CNT_W:0] diff;

    always_comb begin
        sync_d         = {sync_q[1:0], tone_in};
        rise           = sync_q[1] & ~sync_q[2];
        timeout        = !rise && (cnt_q == TO_LAST);

        cnt_d          = cnt_q;
        armed_d        = armed_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        cand_d         = cand_q;
        stable_d       = stable_q;
        note_d         = note_q;
        note_valid_d   = 1'b0;
        match          = 3'd0;
        diff           = '0;

        if (rise) begin
            cnt_d = '0;
            if (armed_q) begin
                period_d       = cnt_q + 1'b1;
                period_valid_d = 1'b1;
            end
            armed_d = 1'b1;
        end else if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Scan downwards so the lowest matching index wins.
        for (int k = 6; k >= 0; k--) begin
            diff = $signed({1'b0, period_q}) - $signed({1'b0, NOTE_V[k]});
            if (diff <= TOL_S && diff >= -TOL_S) match = 3'(k + 1);
        end

        if (timeout) begin
            armed_d  = 1'b0;
            cand_d   = 3'd0;
            stable_d = '0;
            if (note_q != 3'd0) begin
                note_d       = 3'd0;
                note_valid_d = 1'b1;
            end
        end else if (period_valid_q) begin
            if (match == 3'd0) begin
                cand_d   = 3'd0;
                stable_d = '0;
            end else begin
                if (match == cand_q) begin
                    stable_d = (stable_q == STABLE_M) ? stable_q : stable_q + 1'b1;
                end else begin
                    cand_d   = match;
                    stable_d = SW'(1);
                end
                if (stable_d == STABLE_M && cand_d != note_q) begin
                    note_d       = cand_d;
                    note_valid_d = 1'b1;
                end
            end
        end

        locked_d = (note_d != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= '0;
            cnt_q          <= '0;
            armed_q        <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            cand_q         <= 3'd0;
            stable_q       <= '0;
            note_q         <= 3'd0;
            note_valid_q   <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            cnt_q          <= cnt_d;
            armed_q        <= armed_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            cand_q         <= cand_d;
            stable_q       <= stable_d;
            note_q         <= note_d;
            note_valid_q   <= note_valid_d;
            locked_q       <= locked_d;
        end
    end

    assign note         = note_q;
    assign note_valid   = note_valid_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with the note table scaled down by 50 so the
// whole run stays short; TOL and TIMEOUT are scaled to keep the same relationships.
module tb_tone_decoder;

    localparam int CNT_W    = 12;
    localparam int TIMEOUT  = 2000;
    localparam int TOL      = 3;
    localparam int STABLE_N = 3;
    localparam int P_DO = 955, P_RE = 851, P_MI = 758, P_FA = 751;
    localparam int P_SO = 637, P_LA = 568, P_XI = 508;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tone_in = 1'b0;
    logic [2:0]       note;
    logic             note_valid;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;

    int tests_run = 0;
    int tests_failed = 0;
    int pv_cnt = 0;
    int nv_cnt = 0;

    tone_decoder #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL), .STABLE_N(STABLE_N),
        .DO(P_DO), .RE(P_RE), .MI(P_MI), .FA(P_FA), .SO(P_SO), .LA(P_LA), .XI(P_XI)
    ) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in), .note(note), .note_valid(note_valid),
        .period(period), .period_valid(period_valid), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_valid) pv_cnt++;
        if (note_valid) nv_cnt++;
    end

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: run exceeded 80000 cycles");
        $fatal(1, "watchdog");
    end

    // One full period starting with a rising edge; consecutive calls put rises p cycles apart.
    task automatic drive_period(input int p);
        tone_in = 1'b1;
        repeat (p / 2) @(negedge clk);
        tone_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tone_in = ~tone_in;
            @(negedge clk);
            tests_run++;
            if ({note, note_valid, period, period_valid, locked} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got note=%0d nv=%0b period=%0d pv=%0b locked=%0b, want all 0",
                         note, note_valid, period, period_valid, locked);
            end
        end
        rst = 1'b0;
        tone_in = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (pv_cnt !== 0 || nv_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_pulses: got pv=%0d nv=%0d, want 0 0", pv_cnt, nv_cnt);
        end
    endtask

    task automatic test_lock_do();
        int pv0, nv0;
        pv0 = pv_cnt; nv0 = nv_cnt;
        repeat (3) drive_period(P_DO);
        tests_run++;
        if (note !== 3'd0) begin
            tests_failed++;
            $display("FAIL do_not_yet: got note=%0d, want 0", note);
        end
        repeat (2) drive_period(P_DO);
        tests_run++;
        if (pv_cnt - pv0 !== 4) begin
            tests_failed++;
            $display("FAIL do_period_count: got %0d, want 4", pv_cnt - pv0);
        end
        tests_run++;
        if (note !== 3'd1 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL do_note: got note=%0d locked=%0b, want 1 1", note, locked);
        end
        tests_run++;
        if (period !== CNT_W'(P_DO)) begin
            tests_failed++;
            $display("FAIL do_period: got %0d, want %0d", period, P_DO);
        end
        tests_run++;
        if (nv_cnt - nv0 !== 1) begin
            tests_failed++;
            $display("FAIL do_pulses: got %0d, want 1", nv_cnt - nv0);
        end
    endtask

    task automatic test_switch_so();
        int nv0;
        nv0 = nv_cnt;
        repeat (4) drive_period(P_SO);
        tests_run++;
        if (note !== 3'd5 || period !== CNT_W'(P_SO)) begin
            tests_failed++;
            $display("FAIL so_note: got note=%0d period=%0d, want 5 %0d", note, period, P_SO);
        end
        tests_run++;
        if (nv_cnt - nv0 !== 1) begin
            tests_failed++;
            $display("FAIL so_pulses: got %0d, want 1", nv_cnt - nv0);
        end
    endtask

    task automatic test_tolerance();
        int nv0;
        nv0 = nv_cnt;
        repeat (2) drive_period(P_DO + TOL + 1);
        tests_run++;
        if (note !== 3'd5 || period !== CNT_W'(P_DO + TOL + 1)) begin
            tests_failed++;
            $display("FAIL unmatched: got note=%0d period=%0d, want 5 %0d", note, period, P_DO + TOL + 1);
        end
        repeat (4) drive_period(P_FA + 2);
        tests_run++;
        if (note !== 3'd4 || period !== CNT_W'(P_FA + 2)) begin
            tests_failed++;
            $display("FAIL fa_not_mi: got note=%0d period=%0d, want 4 %0d", note, period, P_FA + 2);
        end
        tests_run++;
        if (nv_cnt - nv0 !== 1) begin
            tests_failed++;
            $display("FAIL fa_pulses: got %0d, want 1", nv_cnt - nv0);
        end
    endtask

    task automatic test_alternate();
        int nv0;
        nv0 = nv_cnt;
        for (int i = 0; i < 6; i++) drive_period((i % 2 == 0) ? P_RE : P_MI);
        tests_run++;
        if (note !== 3'd4 || nv_cnt - nv0 !== 0) begin
            tests_failed++;
            $display("FAIL alternate: got note=%0d pulses=%0d, want 4 0", note, nv_cnt - nv0);
        end
        tests_run++;
        if (period !== CNT_W'(P_RE)) begin
            tests_failed++;
            $display("FAIL alternate_period: got %0d, want %0d", period, P_RE);
        end
    endtask

    task automatic test_timeout();
        int waited;
        int exp_wait;
        int pv0, nv0;
        bit seen;
        // Last rise was P_MI cycles before the bench regains control; add synchronizer + commit delay.
        exp_wait = TIMEOUT + 3 - P_MI;
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < TIMEOUT + 50) begin
            @(negedge clk);
            waited++;
            if (note_valid) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL timeout_pulse: no note_valid within %0d cycles", TIMEOUT + 50);
        end
        tests_run++;
        if (waited < exp_wait - 2 || waited > exp_wait + 2) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d cycles, want %0d", waited, exp_wait);
        end
        tests_run++;
        if (note !== 3'd0 || locked !== 1'b0 || period !== CNT_W'(P_RE)) begin
            tests_failed++;
            $display("FAIL timeout_state: got note=%0d locked=%0b period=%0d, want 0 0 %0d",
                     note, locked, period, P_RE);
        end
        @(negedge clk);
        tests_run++;
        if (note_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse_width: got nv=%0b, want 0", note_valid);
        end
        pv0 = pv_cnt;
        drive_period(P_DO);
        tests_run++;
        if (pv_cnt - pv0 !== 0) begin
            tests_failed++;
            $display("FAIL timeout_unarmed: got %0d period pulses, want 0", pv_cnt - pv0);
        end
        // Rise lands exactly on cnt == TIMEOUT-1: rise wins, period = TIMEOUT, unmatched.
        pv0 = pv_cnt; nv0 = nv_cnt;
        drive_period(TIMEOUT);
        drive_period(TIMEOUT);
        drive_period(300);
        tests_run++;
        if (pv_cnt - pv0 !== 3 || period !== CNT_W'(TIMEOUT)) begin
            tests_failed++;
            $display("FAIL simultaneous: got pulses=%0d period=%0d, want 3 %0d", pv_cnt - pv0, period, TIMEOUT);
        end
        tests_run++;
        if (nv_cnt - nv0 !== 0 || note !== 3'd0) begin
            tests_failed++;
            $display("FAIL simultaneous_note: got pulses=%0d note=%0d, want 0 0", nv_cnt - nv0, note);
        end
    endtask

    task automatic test_reset_mid();
        int pv0;
        repeat (2) drive_period(P_DO);
        tone_in = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({note, note_valid, period, period_valid, locked} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got note=%0d nv=%0b period=%0d pv=%0b locked=%0b, want all 0",
                     note, note_valid, period, period_valid, locked);
        end
        rst = 1'b0;
        tone_in = 1'b0;
        repeat (400) @(negedge clk);
        pv0 = pv_cnt;
        drive_period(P_DO);
        tests_run++;
        if (pv_cnt - pv0 !== 0) begin
            tests_failed++;
            $display("FAIL mid_reset_unarmed: got %0d period pulses, want 0", pv_cnt - pv0);
        end
        drive_period(P_DO);
        tests_run++;
        if (pv_cnt - pv0 !== 1 || period !== CNT_W'(P_DO)) begin
            tests_failed++;
            $display("FAIL mid_reset_rearm: got pulses=%0d period=%0d, want 1 %0d", pv_cnt - pv0, period, P_DO);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_lock_do();
        test_switch_so();
        test_tolerance();
        test_alternate();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
